// File: rtl/keypad_io_b3.sv
// Scanned 4x4 keypad reader: walks one low column at a time, snapshots the rows,
// debounces whole scans and latches a key code with valid/overrun flags for the CPU.
module keypad_io_b3 #(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] col,
    input  logic [3:0] row,
    input  logic       key_rd,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       key_overrun,
    output logic       key_pressed
);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

    logic [3:0]          row_meta_q, row_sync_q;
    logic [SCAN_DIV-1:0] presc_q;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [3:0]          col_q;
    logic [11:0]         snap_q;
    logic                tick, scan_done;
    logic [15:0]         snap_full;
    logic [4:0]          hits;
    logic [3:0]          hit_idx;
    logic                res_key;
    logic [3:0]          res_code;
    logic                accept;

    state_t              state_q;
    logic [3:0]          cand_q, cnt_q;
    logic [7:0]          key_code_q;
    logic                key_valid_q, key_overrun_q, key_pressed_q;

    assign tick      = &presc_q;
    assign scan_done = tick && (col_idx_q == 2'd3);
    assign col_idx_d = col_idx_q + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    // Column 3 is never stored: it is merged combinationally on the scan-done tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q   <= '0;
            col_idx_q <= 2'd0;
            col_q     <= 4'b1110;
            snap_q    <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (tick) begin
                col_idx_q <= col_idx_d;
                col_q     <= ~(4'b0001 << col_idx_d);
                case (col_idx_q)
                    2'd0:    snap_q[3:0]  <= ~row_sync_q;
                    2'd1:    snap_q[7:4]  <= ~row_sync_q;
                    2'd2:    snap_q[11:8] <= ~row_sync_q;
                    default: ;
                endcase
            end
        end
    end

    assign snap_full = {~row_sync_q, snap_q};

    always_comb begin
        hits    = 5'd0;
        hit_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap_full[i]) begin
                hits    = hits + 5'd1;
                hit_idx = 4'(i);
            end
        end
    end

    // Snapshot index is col*4+row; zero or multiple hits (ghosting) mean no key.
    assign res_key = (hits == 5'd1);

    always_comb begin
        case (hit_idx)
            4'd0:  res_code = 4'h1;
            4'd1:  res_code = 4'h4;
            4'd2:  res_code = 4'h7;
            4'd3:  res_code = 4'h0;
            4'd4:  res_code = 4'h2;
            4'd5:  res_code = 4'h5;
            4'd6:  res_code = 4'h8;
            4'd7:  res_code = 4'hF;
            4'd8:  res_code = 4'h3;
            4'd9:  res_code = 4'h6;
            4'd10: res_code = 4'h9;
            4'd11: res_code = 4'hE;
            4'd12: res_code = 4'hA;
            4'd13: res_code = 4'hB;
            4'd14: res_code = 4'hC;
            default: res_code = 4'hD;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        if (scan_done && res_key) begin
            if (state_q == IDLE && DB_N == 4'd1)
                accept = 1'b1;
            else if (state_q == PRESS_DB && res_code == cand_q && cnt_q + 4'd1 == DB_N)
                accept = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cand_q        <= 4'd0;
            cnt_q         <= 4'd0;
            key_code_q    <= 8'h00;
            key_valid_q   <= 1'b0;
            key_overrun_q <= 1'b0;
            key_pressed_q <= 1'b0;
        end else begin
            if (scan_done) begin
                case (state_q)
                    IDLE: if (res_key) begin
                        cand_q <= res_code;
                        cnt_q  <= 4'd1;
                        if (DB_N == 4'd1) begin
                            state_q       <= HELD;
                            key_pressed_q <= 1'b1;
                        end else begin
                            state_q <= PRESS_DB;
                        end
                    end
                    PRESS_DB: if (res_key && res_code == cand_q) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == DB_N) begin
                            state_q       <= HELD;
                            key_pressed_q <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                    HELD: if (!res_key) begin
                        cnt_q <= 4'd1;
                        if (DB_N == 4'd1) begin
                            state_q       <= IDLE;
                            key_pressed_q <= 1'b0;
                        end else begin
                            state_q <= REL_DB;
                        end
                    end
                    default: if (!res_key) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == DB_N) begin
                            state_q       <= IDLE;
                            key_pressed_q <= 1'b0;
                        end
                    end else begin
                        state_q <= HELD;
                    end
                endcase
            end
            // A read coinciding with an accept consumes the stale key, not the new one.
            if (accept) begin
                key_code_q    <= {4'h0, res_code};
                key_valid_q   <= 1'b1;
                key_overrun_q <= key_rd ? 1'b0 : (key_overrun_q | key_valid_q);
            end else if (key_rd) begin
                key_valid_q   <= 1'b0;
                key_overrun_q <= 1'b0;
            end
        end
    end

    assign col         = col_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_overrun = key_overrun_q;
    assign key_pressed = key_pressed_q;

endmodule
